// File: rtl/spi_wb_pkg.sv
// Shared types and constants for the SPI-slave to Wishbone-master bridge.
package spi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spiState_t;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_CYCLE = 2'd1,
        BUS_RETRY = 2'd2
    } busState_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_BITS     = 7;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizers for the asynchronous SPI pins plus edge pulses
// derived from the synchronized sck and cs.
module spi_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    output logic cs_sync,
    output logic mosi_sync,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [1:0] sck_ff_r;
    logic [1:0] cs_ff_r;
    logic [1:0] mosi_ff_r;
    logic       sck_prev_r;
    logic       cs_prev_r;

    // Synchronizer chains; cs resets to its inactive (high) level so no edge fires out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_ff_r   <= 2'b00;
            cs_ff_r    <= 2'b11;
            mosi_ff_r  <= 2'b00;
            sck_prev_r <= 1'b0;
            cs_prev_r  <= 1'b1;
        end else begin
            sck_ff_r   <= {sck_ff_r[0], sck};
            cs_ff_r    <= {cs_ff_r[0], cs};
            mosi_ff_r  <= {mosi_ff_r[0], mosi};
            sck_prev_r <= sck_ff_r[1];
            cs_prev_r  <= cs_ff_r[1];
        end
    end

    assign cs_sync   = cs_ff_r[1];
    assign mosi_sync = mosi_ff_r[1];
    assign sck_rise  = sck_ff_r[1] & ~sck_prev_r;
    assign sck_fall  = ~sck_ff_r[1] & sck_prev_r;
    assign cs_rise   = cs_ff_r[1] & ~cs_prev_r;
    assign cs_fall   = ~cs_ff_r[1] & cs_prev_r;

endmodule

// File: rtl/spi_slave_wishbone_bridge.sv
// SPI mode-0 slave that turns host frames (command byte + data bytes) into
// Wishbone master reads/writes with retry, timeout and read prefetch.
module spi_slave_wishbone_bridge
    import spi_wb_pkg::*;
#(
    parameter int         BUS_TIMEOUT = 255,
    parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       misoEn,
    output logic [7:0] ADR_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] DAT_I,
    output logic       WE_O,
    output logic       STB_O,
    output logic       CYC_O,
    input  logic       ACK_I,
    input  logic       RTY_I,
    output logic [1:0] errFlags
);

    localparam int            TW       = $clog2(BUS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

    logic                 cs_sync_s;
    logic                 mosi_sync_s;
    logic                 sck_rise_s;
    logic                 sck_fall_s;
    logic                 cs_rise_s;
    logic                 cs_fall_s;
    spiState_t            spi_state_r;
    spiState_t            spi_next_s;
    busState_t            bus_state_r;
    busState_t            bus_next_s;
    logic [2:0]           bit_cnt_r;
    logic [6:0]           shift_in_r;
    logic [7:0]           rx_byte_s;
    logic                 byte_done_s;
    logic                 is_write_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [ADDR_BITS-1:0] req_addr_s;
    logic                 req_s;
    logic                 req_we_s;
    logic                 post_s;
    logic                 overrun_s;
    logic [TW-1:0]        tmo_cnt_r;
    logic                 ack_s;
    logic                 timeout_s;
    logic [7:0]           read_buf_r;
    logic [7:0]           shift_out_r;
    logic                 rd_valid_r;
    logic                 discard_r;
    logic                 load_pend_r;
    logic                 load_miss_s;
    logic                 stb_r;
    logic                 we_r;
    logic [7:0]           adr_r;
    logic [7:0]           dat_r;
    logic [1:0]           err_r;

    spi_input_sync u_sync (
        .clk       (CLK_I),
        .rst       (RST_I),
        .sck       (sck),
        .cs        (cs),
        .mosi      (mosi),
        .cs_sync   (cs_sync_s),
        .mosi_sync (mosi_sync_s),
        .sck_rise  (sck_rise_s),
        .sck_fall  (sck_fall_s),
        .cs_rise   (cs_rise_s),
        .cs_fall   (cs_fall_s)
    );

    assign rx_byte_s   = {shift_in_r, mosi_sync_s};
    assign byte_done_s = sck_rise_s && !cs_rise_s && (spi_state_r != IDLE) && (bit_cnt_r == 3'd7);

    // Both FSM state registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            spi_state_r <= IDLE;
            bus_state_r <= BUS_IDLE;
        end else begin
            spi_state_r <= spi_next_s;
            bus_state_r <= bus_next_s;
        end
    end

    // Frame FSM: cs rise aborts from any state
    always_comb begin
        spi_next_s = spi_state_r;
        if (cs_rise_s) begin
            spi_next_s = IDLE;
        end else begin
            case (spi_state_r)
                IDLE:    spi_next_s = cs_fall_s ? CMD : IDLE;
                CMD:     spi_next_s = byte_done_s ? DATA : CMD;
                DATA:    spi_next_s = DATA;
                default: spi_next_s = IDLE;
            endcase
        end
    end

    // Bit counter, receive shifter and the frame's direction/address
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            bit_cnt_r  <= 3'd0;
            shift_in_r <= 7'd0;
            is_write_r <= 1'b0;
            addr_r     <= 7'd0;
        end else if (spi_state_r == IDLE || cs_rise_s) begin
            bit_cnt_r  <= 3'd0;
            shift_in_r <= 7'd0;
        end else if (sck_rise_s) begin
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            shift_in_r <= rx_byte_s[6:0];
            if (byte_done_s && spi_state_r == CMD) begin
                is_write_r <= rx_byte_s[CMD_WRITE_BIT];
                addr_r     <= rx_byte_s[ADDR_BITS-1:0];
            end else if (byte_done_s) begin
                addr_r <= addr_r + 7'd1;
            end
        end
    end

    // A read command fetches its start address; read data bytes prefetch the next one
    always_comb begin
        req_s      = 1'b0;
        req_we_s   = 1'b0;
        req_addr_s = addr_r;
        if (byte_done_s && spi_state_r == CMD) begin
            req_s      = !rx_byte_s[CMD_WRITE_BIT];
            req_addr_s = rx_byte_s[ADDR_BITS-1:0];
        end else if (byte_done_s) begin
            req_s      = 1'b1;
            req_we_s   = is_write_r;
            req_addr_s = is_write_r ? addr_r : addr_r + 7'd1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign post_s      = req_s && (bus_state_r == BUS_IDLE);
    assign overrun_s   = req_s && (bus_state_r != BUS_IDLE);
    assign ack_s       = (bus_state_r == BUS_CYCLE) && ACK_I;
    assign timeout_s   = (bus_state_r != BUS_IDLE) && !ack_s && (tmo_cnt_r == TMO_LAST);
    assign load_miss_s = sck_fall_s && load_pend_r && (spi_state_r != IDLE) && !is_write_r && !rd_valid_r;

    // Bus FSM: ACK beats RTY, timeout beats RTY
    always_comb begin
        bus_next_s = bus_state_r;
        case (bus_state_r)
            BUS_IDLE:  bus_next_s = post_s ? BUS_CYCLE : BUS_IDLE;
            BUS_CYCLE: begin
                if (ack_s || timeout_s) begin
                    bus_next_s = BUS_IDLE;
                end else if (RTY_I) begin
                    bus_next_s = BUS_RETRY;
                end else begin
                    bus_next_s = BUS_CYCLE;
                end
            end
            BUS_RETRY: bus_next_s = timeout_s ? BUS_IDLE : BUS_CYCLE;
            default:   bus_next_s = BUS_IDLE;
        endcase
    end

    // Bus outputs, timeout count, and read buffer (data of aborted frames is discarded)
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            adr_r      <= 8'h00;
            dat_r      <= 8'h00;
            tmo_cnt_r  <= TMO_ZERO;
            read_buf_r <= IDLE_FILL;
            rd_valid_r <= 1'b0;
            discard_r  <= 1'b0;
        end else begin
            stb_r <= (bus_next_s == BUS_CYCLE);
            if (cs_fall_s) begin
                rd_valid_r <= 1'b0;
            end
            if (post_s) begin
                adr_r     <= {1'b0, req_addr_s};
                dat_r     <= rx_byte_s;
                we_r      <= req_we_s;
                tmo_cnt_r <= TMO_ZERO;
                if (!req_we_s) begin
                    rd_valid_r <= 1'b0;
                end
            end else if (bus_state_r != BUS_IDLE && bus_next_s == BUS_IDLE) begin
                we_r      <= 1'b0;
                tmo_cnt_r <= TMO_ZERO;
                discard_r <= 1'b0;
                if (!we_r && !discard_r && !cs_rise_s) begin
                    read_buf_r <= ack_s ? DAT_I : IDLE_FILL;
                    rd_valid_r <= 1'b1;
                end
            end else if (bus_state_r != BUS_IDLE) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                if (cs_rise_s) begin
                    discard_r <= 1'b1;
                end
            end
        end
    end

    // miso shifter: reloaded on the sck fall after each completed byte
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            shift_out_r <= 8'h00;
            load_pend_r <= 1'b0;
        end else if (cs_fall_s) begin
            shift_out_r <= IDLE_FILL;
            load_pend_r <= 1'b0;
        end else if (spi_state_r == IDLE) begin
            load_pend_r <= 1'b0;
        end else if (byte_done_s) begin
            load_pend_r <= 1'b1;
        end else if (sck_fall_s && load_pend_r) begin
            load_pend_r <= 1'b0;
            shift_out_r <= (is_write_r || !rd_valid_r) ? IDLE_FILL : read_buf_r;
        end else if (sck_fall_s) begin
            shift_out_r <= {shift_out_r[6:0], 1'b1};
        end
    end

    // Sticky error flags, cleared when a new frame starts
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            err_r <= 2'b00;
        end else begin
            err_r <= (cs_fall_s ? 2'b00 : err_r) | {timeout_s, overrun_s | load_miss_s};
        end
    end

    assign miso     = shift_out_r[7];
    assign misoEn   = ~cs_sync_s;
    assign ADR_O    = adr_r;
    assign DAT_O    = dat_r;
    assign WE_O     = we_r;
    assign STB_O    = stb_r;
    assign CYC_O    = stb_r;
    assign errFlags = err_r;

endmodule

// File: tb/tb_spi_slave_wishbone_bridge.sv
// Directed bench: an SPI host drives frames, a Wishbone slave model answers and logs writes.
module tb_spi_slave_wishbone_bridge;

    localparam int H = 10;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       sck   = 1'b0;
    logic       cs    = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso;
    logic       misoEn;
    logic [7:0] ADR_O;
    logic [7:0] DAT_O;
    logic [7:0] DAT_I = 8'h00;
    logic       WE_O;
    logic       STB_O;
    logic       CYC_O;
    logic       ACK_I = 1'b0;
    logic       RTY_I = 1'b0;
    logic [1:0] errFlags;

    int checks = 0;
    int errors = 0;

    // Slave model controls (written by the stimulus only)
    logic       ack_en = 1'b1;
    int         ack_delay = 1;
    int         rty_budget = 0;
    logic [7:0] mem [0:127];

    // Slave model observations (written by the responder only)
    int         wr_cnt = 0;
    int         acks = 0;
    int         rty_seen = 0;
    int         stb_cycles = 0;
    int         stb_starts = 0;
    int         low_cnt = 0;
    int         last_gap = 0;
    int         wait_cnt = 0;
    logic       stb_prev = 1'b0;
    logic [7:0] log_adr [0:63];
    logic [7:0] log_dat [0:63];

    spi_slave_wishbone_bridge dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .sck      (sck),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .misoEn   (misoEn),
        .ADR_O    (ADR_O),
        .DAT_O    (DAT_O),
        .DAT_I    (DAT_I),
        .WE_O     (WE_O),
        .STB_O    (STB_O),
        .CYC_O    (CYC_O),
        .ACK_I    (ACK_I),
        .RTY_I    (RTY_I),
        .errFlags (errFlags)
    );

    always #5 CLK_I = ~CLK_I;

    // Wishbone slave: answers on the falling edge so the DUT samples stable inputs
    always @(negedge CLK_I) begin
        ACK_I = 1'b0;
        RTY_I = 1'b0;
        if (STB_O) begin
            if (!stb_prev) begin
                stb_starts++;
                last_gap = low_cnt;
            end
            stb_cycles++;
            wait_cnt++;
            low_cnt = 0;
            if (rty_seen < rty_budget) begin
                RTY_I = 1'b1;
                rty_seen++;
                wait_cnt = 0;
            end else if (ack_en && wait_cnt >= ack_delay) begin
                ACK_I = 1'b1;
                DAT_I = mem[ADR_O[6:0]];
                acks++;
                if (WE_O) begin
                    log_adr[wr_cnt] = ADR_O;
                    log_dat[wr_cnt] = DAT_O;
                    wr_cnt++;
                end
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
            low_cnt++;
        end
        stb_prev = STB_O;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    // Mode-0 host: mosi set while sck low, miso sampled just before the rising edge
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int last_high,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(H);
            rx[i] = miso;
            sck = 1'b1;
            wait_clk((i == 8 - nbits) ? last_high : H);
            sck = 1'b0;
        end
    endtask

    task automatic cs_start();
        cs = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_end();
        wait_clk(H);
        cs = 1'b1;
        wait_clk(4 * H);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        int         w0;
        int         a0;
        int         s0;
        int         r0;

        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'(i ^ 8'h40);
        end
        mem[5] = 8'hA5;
        mem[6] = 8'h5A;

        // Reset state
        wait_clk(5);
        check("rst_stb", 32'(STB_O), 32'h0);
        check("rst_cyc", 32'(CYC_O), 32'h0);
        check("rst_we", 32'(WE_O), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_misoEn", 32'(misoEn), 32'h0);
        check("rst_adr", 32'(ADR_O), 32'h0);
        check("rst_dat", 32'(DAT_O), 32'h0);
        check("rst_err", 32'(errFlags), 32'h0);
        RST_I = 1'b0;
        wait_clk(5);

        // Single write 0x85,0x3C
        w0 = wr_cnt;
        a0 = acks;
        cs_start();
        check("t1_misoEn_on", 32'(misoEn), 32'h1);
        spi_bits(8'h85, 8, H, rx);
        check("t1_cmd_miso", 32'(rx), 32'hFF);
        spi_bits(8'h3C, 8, H, rx);
        check("t1_data_miso", 32'(rx), 32'hFF);
        cs_end();
        check("t1_nwrites", 32'(wr_cnt - w0), 32'h1);
        check("t1_nacks", 32'(acks - a0), 32'h1);
        check("t1_adr", 32'(log_adr[w0]), 32'h05);
        check("t1_dat", 32'(log_dat[w0]), 32'h3C);
        check("t1_err", 32'(errFlags), 32'h0);
        check("t1_misoEn_off", 32'(misoEn), 32'h0);
        check("t1_stb_idle", 32'(STB_O), 32'h0);

        // Burst write wrapping 0x7F -> 0x00
        w0 = wr_cnt;
        cs_start();
        spi_bits(8'hFF, 8, H, rx);
        spi_bits(8'h11, 8, H, rx);
        spi_bits(8'h22, 8, H, rx);
        cs_end();
        check("t2_nwrites", 32'(wr_cnt - w0), 32'h2);
        check("t2_adr0", 32'(log_adr[w0]), 32'h7F);
        check("t2_dat0", 32'(log_dat[w0]), 32'h11);
        check("t2_adr1", 32'(log_adr[w0 + 1]), 32'h00);
        check("t2_dat1", 32'(log_dat[w0 + 1]), 32'h22);

        // Read burst from 0x05 with two-cycle ACK latency
        ack_delay = 2;
        w0 = wr_cnt;
        cs_start();
        spi_bits(8'h05, 8, H, rx);
        check("t3_cmd_miso", 32'(rx), 32'hFF);
        spi_bits(8'h00, 8, H, rx);
        check("t3_rx0", 32'(rx), 32'hA5);
        spi_bits(8'h00, 8, H, rx);
        check("t3_rx1", 32'(rx), 32'h5A);
        cs_end();
        check("t3_prefetch_adr", 32'(ADR_O), 32'h07);
        check("t3_no_writes", 32'(wr_cnt - w0), 32'h0);
        check("t3_err", 32'(errFlags), 32'h0);
        ack_delay = 1;

        // Write with one retry then ACK
        w0 = wr_cnt;
        s0 = stb_starts;
        r0 = rty_seen;
        rty_budget = rty_seen + 1;
        cs_start();
        spi_bits(8'h90, 8, H, rx);
        spi_bits(8'h77, 8, H, rx);
        cs_end();
        check("t4_nwrites", 32'(wr_cnt - w0), 32'h1);
        check("t4_adr", 32'(log_adr[w0]), 32'h10);
        check("t4_dat", 32'(log_dat[w0]), 32'h77);
        check("t4_retries", 32'(rty_seen - r0), 32'h1);
        check("t4_strobes", 32'(stb_starts - s0), 32'h2);
        check("t4_gap", 32'(last_gap), 32'h1);
        check("t4_err", 32'(errFlags), 32'h0);

        // Read that is never acknowledged: timeout after 255 strobe cycles
        ack_en = 1'b0;
        s0 = stb_cycles;
        cs_start();
        spi_bits(8'h20, 8, 280, rx);
        check("t5_stb_len", 32'(stb_cycles - s0), 32'd255);
        check("t5_stb_low", 32'(STB_O), 32'h0);
        check("t5_err_mid", 32'(errFlags), 32'h2);
        spi_bits(8'h00, 8, 280, rx);
        check("t5_rx", 32'(rx), 32'hFF);
        cs_end();
        check("t5_err", 32'(errFlags), 32'h2);
        check("t5_prefetch_adr", 32'(ADR_O), 32'h21);
        ack_en = 1'b1;

        // cs rises 3 bits into a data byte: no bus cycle; the frame's cs fall clears errors
        s0 = stb_starts;
        cs_start();
        check("t6_err_cleared", 32'(errFlags), 32'h0);
        spi_bits(8'h83, 8, H, rx);
        spi_bits(8'hE0, 3, H, rx);
        cs_end();
        check("t6_no_strobe", 32'(stb_starts - s0), 32'h0);
        w0 = wr_cnt;
        cs_start();
        spi_bits(8'h84, 8, H, rx);
        spi_bits(8'h66, 8, H, rx);
        cs_end();
        check("t6_next_nwrites", 32'(wr_cnt - w0), 32'h1);
        check("t6_next_adr", 32'(log_adr[w0]), 32'h04);
        check("t6_next_dat", 32'(log_dat[w0]), 32'h66);

        // Reset in the middle of a pending write cycle
        ack_en = 1'b0;
        cs_start();
        spi_bits(8'h81, 8, H, rx);
        spi_bits(8'h99, 8, H, rx);
        check("t7_stb_pending", 32'(STB_O), 32'h1);
        RST_I = 1'b1;
        wait_clk(1);
        check("t7_stb_reset", 32'(STB_O), 32'h0);
        check("t7_cyc_reset", 32'(CYC_O), 32'h0);
        check("t7_we_reset", 32'(WE_O), 32'h0);
        check("t7_adr_reset", 32'(ADR_O), 32'h0);
        cs = 1'b1;
        sck = 1'b0;
        wait_clk(4);
        RST_I = 1'b0;
        ack_en = 1'b1;
        wait_clk(4);
        w0 = wr_cnt;
        cs_start();
        spi_bits(8'h82, 8, H, rx);
        spi_bits(8'h44, 8, H, rx);
        cs_end();
        check("t7_after_nwrites", 32'(wr_cnt - w0), 32'h1);
        check("t7_after_adr", 32'(log_adr[w0]), 32'h02);
        check("t7_after_dat", 32'(log_dat[w0]), 32'h44);
        check("t7_after_err", 32'(errFlags), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
